regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Writeback stage for the single-issue RISC-V core, sitting directly upstream of the 32x32 register file's write port. It accepts results from two producers (ALU and load unit) over valid/ready handshakes and arbitrates between them with a starvation guard. It sign- or zero-extends and aligns load data, then drives the register file's `wr_ena`/`wr_addr`/`wr_data` from a registered stage. An optional bypass path forwards the in-flight write to the register file's two read channels.

## Interface
- `STARVE_LIMIT`, default 4: consecutive ALU stall cycles before the ALU gets priority. Legal range 1..7.
- `clk` in 1: single clock; all state on posedge.
- `rst` in 1: synchronous, active-high reset.
- `alu_valid` in 1: ALU result available.
- `alu_ready` out 1: ALU result accepted this cycle.
- `alu_rd` in 5: destination register.
- `alu_result` in 32: value to write.
- `ld_valid` in 1: load result available.
- `ld_ready` out 1: load result accepted this cycle.
- `ld_rd` in 5: destination register.
- `ld_funct3` in 3: RV32I load type (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu).
- `ld_addr_lsb` in 2: byte offset of the load address.
- `ld_word` in 32: aligned 32-bit word from memory.
- `ld_err` out 1: one-cycle pulse flagging a misaligned or illegal load.
- `wr_ena` out 1: register file write enable.
- `wr_addr` out 5: register file write address.
- `wr_data` out 32: register file write data.
- `rd_addr0`, `rd_addr1` in 5: register file read addresses, used for bypass.
- `fwd_hit0`, `fwd_hit1` out 1: in-flight write matches the corresponding read address.
- `fwd_data0`, `fwd_data1` out 32: forwarded value.

## Operation
- Reset values: `wr_ena`=0, `wr_addr`=0, `wr_data`=0, `ld_err`=0, starvation counter=0.
- `alu_ready` and `ld_ready` are both 0 while `rst`=1.
- Arbitration:
  - `alu_pri` = (counter == `STARVE_LIMIT`).
  - `ld_ready` = !rst & !(alu_pri & alu_valid).
  - `alu_ready` = !rst & (!ld_valid | alu_pri).
  - Readies are combinational and independent of the other channel's ready. At most one channel is accepted per cycle.
- Starvation counter:
  - Increments, saturating at `STARVE_LIMIT`, on each cycle where `alu_valid` & !`alu_ready`.
  - Clears to 0 on ALU acceptance or when `alu_valid`=0.
- Load extraction: the byte or half is selected by `ld_addr_lsb`.
  - lb and lh sign-extend; lbu and lhu zero-extend; lw passes `ld_word` through.
- Load errors:
  - Misaligned: lh/lhu with lsb[0]=1, or lw with lsb≠0.
  - Illegal: funct3 ∈ {011, 110, 111}.
  - Either case: the load is accepted, no write is issued, and `ld_err` is 1 for the following cycle.
- x0 suppression: an accepted result with rd=0 produces `wr_ena`=0. `wr_addr`/`wr_data` may still update.
- Bypass (`fwd_hitN`, `fwd_dataN`):
  - `fwd_hitN` = `wr_ena` & (`rd_addrN` == `wr_addr`); `fwd_dataN` = `wr_data`.
  - Purely combinational from the registered stage. Never hits for address 0.

## Timing
- Accept on posedge N: `wr_*` valid during cycle N+1; the register file captures the value at posedge N+2.
- Throughput: one write per cycle, no bubbles.
- `wr_ena` is 0 in any cycle following one with no acceptance.
- During cycle N+1 a read of the same register returns the stale value; bypass supplies the new one.
- Both channels valid: the load wins unless `alu_pri`. With `STARVE_LIMIT`=4 and `ld_valid` held high, the ALU is accepted on its 5th valid cycle; the load stalls that one cycle.
- Reset asserted mid-stream: at the next posedge `wr_ena`=0, the counter clears and the pending write is dropped. Producers must hold their data since ready was 0.

## Configuration
- `WB_FORWARD_EN` defined: bypass logic as described.
- Not defined: `fwd_hit0`/`fwd_hit1` tied 0 and `fwd_data0`/`fwd_data1` tied 32'd0. Ports remain on the module, and all other behaviour is unchanged.

## Test plan
- ALU only, rd=5, result=0xDEADBEEF, accepted at edge N -> `wr_ena`=1, `wr_addr`=5, `wr_data`=0xDEADBEEF during N+1; `wr_ena`=0 during N+2.
- Loads with `ld_word`=0x80FF7F01:
  - lb lsb=3 -> 0xFFFFFF80.
  - lbu lsb=2 -> 0x000000FF.
  - lh lsb=2 -> 0xFFFF80FF.
  - lhu lsb=0 -> 0x00007F01.
  - lw lsb=0 -> 0x80FF7F01.
- lw lsb=2, then funct3=011 -> each accepted with `wr_ena`=0 and a one-cycle `ld_err`=1 pulse.
- ALU rd=0, value 0x1234 -> accepted, `wr_ena`=0, `fwd_hit0`=0 with `rd_addr0`=0.
- Starvation, `STARVE_LIMIT`=4, both valid continuously -> `alu_ready`=1 on exactly every 5th cycle, all other cycles go to the load, no lost or duplicated writes.
- With `WB_FORWARD_EN`, write rd=7 value 0x55 in flight and `rd_addr1`=7 -> `fwd_hit1`=1, `fwd_data1`=0x55. Assert `rst` that cycle -> next cycle `wr_ena`=0 and `fwd_hit1`=0.

Source files
------------

// File: rtl/regfile_writeback.sv
// Writeback stage: arbitrates ALU and load results into the register file write port.
// Optional bypass to the read channels is enabled by defining WB_FORWARD_EN.
module regfile_writeback #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_result,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lsb,
  input  logic [31:0] ld_word,
  output logic        ld_err,
  output logic        wr_ena,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  input  logic [4:0]  rd_addr0,
  input  logic [4:0]  rd_addr1,
  output logic        fwd_hit0,
  output logic        fwd_hit1,
  output logic [31:0] fwd_data0,
  output logic [31:0] fwd_data1
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [2:0]  cnt_q, cnt_d;
  logic        wr_ena_q, wr_ena_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        ld_err_q, ld_err_d;

  logic        alu_pri, alu_acc, ld_acc, ld_bad;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign alu_pri   = (cnt_q == LIMIT);
  assign ld_ready  = !rst && !(alu_pri && alu_valid);
  assign alu_ready = !rst && (!ld_valid || alu_pri);
  assign alu_acc   = alu_valid && alu_ready;
  assign ld_acc    = ld_valid && ld_ready;

  assign ld_byte = ld_word[{ld_addr_lsb, 3'b000} +: 8];
  assign ld_half = ld_addr_lsb[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    ld_ext = ld_word;
    ld_bad = 1'b0;
    case (ld_funct3)
      3'b000: ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001: begin
        ld_ext = {{16{ld_half[15]}}, ld_half};
        ld_bad = ld_addr_lsb[0];
      end
      3'b010: ld_bad = (ld_addr_lsb != 2'b00);
      3'b100: ld_ext = {24'd0, ld_byte};
      3'b101: begin
        ld_ext = {16'd0, ld_half};
        ld_bad = ld_addr_lsb[0];
      end
      default: ld_bad = 1'b1;
    endcase
  end

  // Next-state: at most one channel accepted; x0 and faulting loads never write.
  always_comb begin
    cnt_d     = cnt_q;
    wr_ena_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ld_err_d  = 1'b0;
    if (!alu_valid || alu_acc) begin
      cnt_d = 3'd0;
    end else if (cnt_q < LIMIT) begin
      cnt_d = cnt_q + 3'd1;
    end
    if (alu_acc) begin
      wr_ena_d  = (alu_rd != 5'd0);
      wr_addr_d = alu_rd;
      wr_data_d = alu_result;
    end else if (ld_acc) begin
      wr_ena_d  = !ld_bad && (ld_rd != 5'd0);
      wr_addr_d = ld_rd;
      wr_data_d = ld_ext;
      ld_err_d  = ld_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 3'd0;
      wr_ena_q  <= 1'b0;
      wr_addr_q <= 5'd0;
      wr_data_q <= 32'd0;
      ld_err_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      wr_ena_q  <= wr_ena_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ld_err_q  <= ld_err_d;
    end
  end

  assign wr_ena  = wr_ena_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign ld_err  = ld_err_q;

`ifdef WB_FORWARD_EN
  assign fwd_hit0  = wr_ena_q && (wr_addr_q != 5'd0) && (rd_addr0 == wr_addr_q);
  assign fwd_hit1  = wr_ena_q && (wr_addr_q != 5'd0) && (rd_addr1 == wr_addr_q);
  assign fwd_data0 = wr_data_q;
  assign fwd_data1 = wr_data_q;
`else
  logic unused_rd;
  assign unused_rd = ^{rd_addr0, rd_addr1};
  assign fwd_hit0  = 1'b0;
  assign fwd_hit1  = 1'b0;
  assign fwd_data0 = 32'd0;
  assign fwd_data1 = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback (STARVE_LIMIT = 4).
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lsb;
  logic [31:0] ld_word;
  logic        ld_err, wr_ena;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr0, rd_addr1;
  logic        fwd_hit0, fwd_hit1;
  logic [31:0] fwd_data0, fwd_data1;

  int errors = 0;
  int checks = 0;

  regfile_writeback #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_result(alu_result),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_funct3(ld_funct3),
    .ld_addr_lsb(ld_addr_lsb), .ld_word(ld_word), .ld_err(ld_err),
    .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .fwd_hit0(fwd_hit0), .fwd_hit1(fwd_hit1), .fwd_data0(fwd_data0), .fwd_data1(fwd_data1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; alu_valid = 1'b1; ld_valid = 1'b1;
    alu_rd = 5'd1; alu_result = 32'h1111_1111; ld_rd = 5'd2;
    ld_funct3 = 3'b010; ld_addr_lsb = 2'd0; ld_word = 32'h2222_2222;
    rd_addr0 = 5'd0; rd_addr1 = 5'd0;
    #1;
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL rst_alu_ready got=%b exp=0", alu_ready); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL rst_ld_ready got=%b exp=0", ld_ready); end
    step(); step();
    checks++; if (wr_ena !== 1'b0) begin errors++; $display("FAIL rst_wr_ena got=%b exp=0", wr_ena); end
    checks++; if (wr_addr !== 5'd0) begin errors++; $display("FAIL rst_wr_addr got=%0d exp=0", wr_addr); end
    checks++; if (wr_data !== 32'd0) begin errors++; $display("FAIL rst_wr_data got=%h exp=0", wr_data); end
    checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL rst_ld_err got=%b exp=0", ld_err); end
    alu_valid = 1'b0; ld_valid = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_alu();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_result = 32'hDEADBEEF;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_ready got=%b exp=1", alu_ready); end
    step();
    alu_valid = 1'b0;
    checks++; if (wr_ena !== 1'b1) begin errors++; $display("FAIL alu_wr_ena got=%b exp=1", wr_ena); end
    checks++; if (wr_addr !== 5'd5) begin errors++; $display("FAIL alu_wr_addr got=%0d exp=5", wr_addr); end
    checks++; if (wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_wr_data got=%h exp=deadbeef", wr_data); end
    step();
    checks++; if (wr_ena !== 1'b0) begin errors++; $display("FAIL alu_idle_wr_ena got=%b exp=0", wr_ena); end
  endtask

  task automatic test_back_to_back();
    alu_valid = 1'b1; alu_rd = 5'd6; alu_result = 32'h0000_0A0A;
    step();
    alu_rd = 5'd8; alu_result = 32'h0000_0B0B;
    checks++; if (wr_ena !== 1'b1 || wr_addr !== 5'd6 || wr_data !== 32'h0A0A) begin
      errors++; $display("FAIL b2b_first got=%b/%0d/%h exp=1/6/00000a0a", wr_ena, wr_addr, wr_data); end
    step();
    alu_valid = 1'b0;
    checks++; if (wr_ena !== 1'b1 || wr_addr !== 5'd8 || wr_data !== 32'h0B0B) begin
      errors++; $display("FAIL b2b_second got=%b/%0d/%h exp=1/8/00000b0b", wr_ena, wr_addr, wr_data); end
    step();
  endtask

  task automatic test_loads();
    logic [2:0]  f3 [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  ls [5] = '{2'd3, 2'd2, 2'd2, 2'd0, 2'd0};
    logic [31:0] ex [5] = '{32'hFFFFFF80, 32'h000000FF, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
    ld_word = 32'h80FF7F01;
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1; ld_funct3 = f3[i]; ld_addr_lsb = ls[i]; ld_rd = 5'(10 + i);
      #1;
      checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL ld_ready[%0d] got=%b exp=1", i, ld_ready); end
      step();
      ld_valid = 1'b0;
      checks++; if (wr_ena !== 1'b1 || wr_addr !== 5'(10 + i) || wr_data !== ex[i] || ld_err !== 1'b0) begin
        errors++; $display("FAIL load[%0d] got=%b/%0d/%h err=%b exp=1/%0d/%h err=0",
                           i, wr_ena, wr_addr, wr_data, ld_err, 10 + i, ex[i]); end
    end
    step();
  endtask

  task automatic test_ld_err();
    logic [2:0] f3 [3] = '{3'b010, 3'b011, 3'b101};
    logic [1:0] ls [3] = '{2'd2, 2'd0, 2'd1};
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_funct3 = f3[i]; ld_addr_lsb = ls[i]; ld_rd = 5'd12; ld_word = 32'h1234_5678;
      #1;
      checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL err_ld_ready[%0d] got=%b exp=1", i, ld_ready); end
      step();
      ld_valid = 1'b0;
      checks++; if (wr_ena !== 1'b0 || ld_err !== 1'b1) begin
        errors++; $display("FAIL err_pulse[%0d] got wr_ena=%b ld_err=%b exp 0/1", i, wr_ena, ld_err); end
      step();
      checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL err_clear[%0d] got=%b exp=0", i, ld_err); end
    end
  endtask

  task automatic test_x0();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_result = 32'h0000_1234; rd_addr0 = 5'd0;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got=%b exp=1", alu_ready); end
    step();
    alu_valid = 1'b0;
    checks++; if (wr_ena !== 1'b0) begin errors++; $display("FAIL x0_wr_ena got=%b exp=0", wr_ena); end
    checks++; if (fwd_hit0 !== 1'b0) begin errors++; $display("FAIL x0_fwd_hit0 got=%b exp=0", fwd_hit0); end
    step();
  endtask

  task automatic test_starvation();
    int na = 0, nl = 0;
    logic exp_alu;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_result = 32'hA000_0000;
    ld_valid = 1'b1; ld_rd = 5'd3; ld_funct3 = 3'b010; ld_addr_lsb = 2'd0; ld_word = 32'hB000_0000;
    for (int k = 1; k <= 15; k++) begin
      exp_alu = (k % 5 == 0);
      #1;
      checks++; if (alu_ready !== exp_alu || ld_ready !== !exp_alu) begin
        errors++; $display("FAIL starve_ready[%0d] got alu=%b ld=%b exp alu=%b", k, alu_ready, ld_ready, exp_alu); end
      step();
      checks++; if (exp_alu ? (wr_ena !== 1'b1 || wr_addr !== 5'd4 || wr_data !== 32'hA000_0000 + 32'(na))
                            : (wr_ena !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 32'hB000_0000 + 32'(nl))) begin
        errors++; $display("FAIL starve_write[%0d] got=%b/%0d/%h alu_turn=%b", k, wr_ena, wr_addr, wr_data, exp_alu); end
      if (exp_alu) begin na++; alu_result = 32'hA000_0000 + 32'(na); end
      else begin nl++; ld_word = 32'hB000_0000 + 32'(nl); end
    end
    checks++; if (na != 3 || nl != 12) begin errors++; $display("FAIL starve_counts got alu=%0d ld=%0d exp 3/12", na, nl); end
    alu_valid = 1'b0; ld_valid = 1'b0;
    step();
  endtask

  task automatic test_forward_reset();
    logic exp_hit;
`ifdef WB_FORWARD_EN
    exp_hit = 1'b1;
`else
    exp_hit = 1'b0;
`endif
    alu_valid = 1'b1; alu_rd = 5'd7; alu_result = 32'h55;
    step();
    alu_rd = 5'd9; alu_result = 32'h99; rd_addr1 = 5'd7; rd_addr0 = 5'd8;
    #1;
    checks++; if (fwd_hit1 !== exp_hit || fwd_data1 !== (exp_hit ? 32'h55 : 32'd0)) begin
      errors++; $display("FAIL fwd1 got hit=%b data=%h exp hit=%b", fwd_hit1, fwd_data1, exp_hit); end
    checks++; if (fwd_hit0 !== 1'b0) begin errors++; $display("FAIL fwd0_miss got=%b exp=0", fwd_hit0); end
    rst = 1'b1;
    #1;
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%b exp=0", alu_ready); end
    step();
    checks++; if (wr_ena !== 1'b0 || fwd_hit1 !== 1'b0) begin
      errors++; $display("FAIL midrst got wr_ena=%b fwd_hit1=%b exp 0/0", wr_ena, fwd_hit1); end
    rst = 1'b0; alu_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_loads();
    test_ld_err();
    test_x0();
    test_starvation();
    test_forward_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
